// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: merges decode redirects, hazard stalls, eret and the interrupt entry sequence.
// Optional macro FETCH_CTRL_HALT_EN adds the i_halt input and a HALT state.
module fetch_ctrl #(
    parameter  int INSTR_ADDR_WIDTH = 30,
    parameter  int DRAIN_CYCLES     = 3,
    localparam int PC_WIDTH         = INSTR_ADDR_WIDTH - 2,
    parameter  logic [PC_WIDTH-1:0] IRQ_VECTOR = 28'h0000040
) (
    input  logic                i_clk,
    input  logic                i_arst,
    input  logic                i_br_taken,
    input  logic [PC_WIDTH-1:0] i_br_target,
    input  logic                i_hazard_stall,
    input  logic                i_eret,
    input  logic [PC_WIDTH-1:0] i_epc,
    input  logic                i_irq,
`ifdef FETCH_CTRL_HALT_EN
    input  logic                i_halt,
`endif
    output logic                o_jmp_en,
    output logic [PC_WIDTH-1:0] o_pc_jmp,
    output logic                o_stall_en,
    output logic                o_fe_kill,
    output logic                o_irq_ack,
    output logic                o_in_handler
);

`ifdef FETCH_CTRL_HALT_EN
    typedef enum logic [1:0] {RUN, DRAIN, VECTOR, HALT} state_e;
`else
    typedef enum logic [1:0] {RUN, DRAIN, VECTOR} state_e;
`endif

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          in_handler_q, in_handler_d;

    logic                jmp_en;
    logic [PC_WIDTH-1:0] pc_jmp;
    logic                stall_en;
    logic                fe_kill;
    logic                irq_ack;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            in_handler_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            in_handler_q <= in_handler_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        in_handler_d = in_handler_q;
        jmp_en       = 1'b0;
        pc_jmp       = '0;
        stall_en     = 1'b0;
        fe_kill      = 1'b0;
        irq_ack      = 1'b0;

        unique case (state_q)
            RUN: begin
                if (i_eret) begin
                    jmp_en       = 1'b1;
                    pc_jmp       = i_epc;
                    in_handler_d = 1'b0;
                end else if (i_br_taken) begin
                    jmp_en = 1'b1;
                    pc_jmp = i_br_target;
`ifdef FETCH_CTRL_HALT_EN
                end else if (i_halt) begin
                    stall_en = 1'b1;
                    state_d  = HALT;
`endif
                end else if (i_irq && !in_handler_q) begin
                    // The kill supersedes any concurrent hazard stall.
                    fe_kill  = 1'b1;
                    stall_en = 1'b1;
                    state_d  = DRAIN;
                    cnt_d    = DRAIN_INIT;
                end else if (i_hazard_stall) begin
                    stall_en = 1'b1;
                end
            end
            DRAIN: begin
                fe_kill  = 1'b1;
                stall_en = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = VECTOR;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            VECTOR: begin
                jmp_en       = 1'b1;
                pc_jmp       = IRQ_VECTOR;
                irq_ack      = 1'b1;
                in_handler_d = 1'b1;
                state_d      = RUN;
            end
`ifdef FETCH_CTRL_HALT_EN
            HALT: begin
                fe_kill  = 1'b1;
                stall_en = 1'b1;
                if (i_irq && !in_handler_q) begin
                    state_d = DRAIN;
                    cnt_d   = DRAIN_INIT;
                end else if (!i_halt) begin
                    state_d = RUN;
                end
            end
`endif
            default: state_d = RUN;
        endcase
    end

    // Outputs are held at zero for the whole time reset is asserted.
    always_comb begin
        o_jmp_en     = jmp_en   & ~i_arst;
        o_pc_jmp     = i_arst ? '0 : pc_jmp;
        o_stall_en   = stall_en & ~i_arst;
        o_fe_kill    = fe_kill  & ~i_arst;
        o_irq_ack    = irq_ack  & ~i_arst;
        o_in_handler = in_handler_q & ~i_arst;
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a sequence-level reference model compared every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_fetch_ctrl;
    localparam int PCW = 28;
    localparam int DC  = 3;
    localparam logic [PCW-1:0] VEC = 28'h40;

    logic           clk = 1'b0;
    logic           arst;
    logic           br_taken, hazard_stall, eret, irq;
    logic [PCW-1:0] br_target, epc;
    logic           o_jmp_en, o_stall_en, o_fe_kill, o_irq_ack, o_in_handler;
    logic [PCW-1:0] o_pc_jmp;

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(.INSTR_ADDR_WIDTH(30), .DRAIN_CYCLES(DC), .IRQ_VECTOR(VEC)) dut (
        .i_clk(clk), .i_arst(arst),
        .i_br_taken(br_taken), .i_br_target(br_target),
        .i_hazard_stall(hazard_stall),
        .i_eret(eret), .i_epc(epc), .i_irq(irq),
        .o_jmp_en(o_jmp_en), .o_pc_jmp(o_pc_jmp), .o_stall_en(o_stall_en),
        .o_fe_kill(o_fe_kill), .o_irq_ack(o_irq_ack), .o_in_handler(o_in_handler)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_left < 0 means normal running; otherwise it counts the
    // remaining kill cycles of an interrupt entry, with 0 meaning "vector this cycle".
    int m_left = -1;
    bit m_ih   = 1'b0;

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            m_left <= -1;
            m_ih   <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
        end else if (m_left == 0) begin
            m_left <= -1;
            m_ih   <= 1'b1;
        end else if (eret) begin
            m_ih <= 1'b0;
        end else if (!br_taken && irq && !m_ih) begin
            m_left <= DC;
        end
    end

    // Packed as {jmp_en, pc_jmp, stall_en, fe_kill, irq_ack, in_handler}.
    function automatic logic [32:0] model_out();
        logic           j = 1'b0, s = 1'b0, k = 1'b0, a = 1'b0;
        logic [PCW-1:0] pc = '0;
        if (arst) return '0;
        if (m_left > 0) begin
            k = 1'b1; s = 1'b1;
        end else if (m_left == 0) begin
            j = 1'b1; pc = VEC; a = 1'b1;
        end else if (eret) begin
            j = 1'b1; pc = epc;
        end else if (br_taken) begin
            j = 1'b1; pc = br_target;
        end else if (irq && !m_ih) begin
            k = 1'b1; s = 1'b1;
        end else if (hazard_stall) begin
            s = 1'b1;
        end
        return {j, pc, s, k, a, m_ih};
    endfunction

    wire [32:0] dut_out = {o_jmp_en, o_pc_jmp, o_stall_en, o_fe_kill, o_irq_ack, o_in_handler};

    always @(negedge clk) check("model", 64'(dut_out), 64'(model_out()));

    task automatic clear_inputs();
        br_taken = 0; br_target = '0; hazard_stall = 0; eret = 0; epc = '0; irq = 0;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ctl(input string name, input logic j, input logic [PCW-1:0] pc,
                              input logic s, input logic k, input logic a);
        check({name, ".jmp_en"},   64'(o_jmp_en),   64'(j));
        check({name, ".pc_jmp"},   64'(o_pc_jmp),   64'(pc));
        check({name, ".stall_en"}, 64'(o_stall_en), 64'(s));
        check({name, ".fe_kill"},  64'(o_fe_kill),  64'(k));
        check({name, ".irq_ack"},  64'(o_irq_ack),  64'(a));
    endtask

    initial begin
        // 1. Reset with every input high.
        arst = 1'b1;
        br_taken = 1; br_target = 28'hFFF; hazard_stall = 1; eret = 1; epc = 28'hABC; irq = 1;
        @(negedge clk);
        expect_ctl("reset", 0, '0, 0, 0, 0);
        check("reset.in_handler", 64'(o_in_handler), 64'd0);
        adv();
        arst = 1'b0;
        clear_inputs();
        @(negedge clk);
        expect_ctl("run_idle", 0, '0, 0, 0, 0);
        check("run_idle.in_handler", 64'(o_in_handler), 64'd0);
        adv();

        // 2. Branch beats hazard stall.
        br_taken = 1; br_target = 28'h100; hazard_stall = 1;
        @(negedge clk);
        expect_ctl("br_vs_stall", 1, 28'h100, 0, 0, 0);
        adv();
        clear_inputs();

        // 3. Interrupt entry; irq drops after accept and redirects in DRAIN are ignored.
        irq = 1;
        @(negedge clk);
        expect_ctl("irq_accept", 0, '0, 1, 1, 0);
        adv();
        irq = 0;
        for (int i = 1; i <= DC; i++) begin
            if (i == 2) begin br_taken = 1; br_target = 28'h77; eret = 1; epc = 28'h55; end
            @(negedge clk);
            expect_ctl("drain", 0, '0, 1, 1, 0);
            adv();
            clear_inputs();
        end
        @(negedge clk);
        expect_ctl("vector", 1, 28'h40, 0, 0, 1);
        check("vector.in_handler", 64'(o_in_handler), 64'd0);
        adv();
        @(negedge clk);
        check("handler_set", 64'(o_in_handler), 64'd1);
        expect_ctl("after_vector", 0, '0, 0, 0, 0);

        // 5. Nested irq blocked, eret releases it, then it is accepted.
        irq = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            expect_ctl("masked_irq", 0, '0, 0, 0, 0);
            adv();
        end
        eret = 1; epc = 28'h33;
        @(negedge clk);
        expect_ctl("eret", 1, 28'h33, 0, 0, 0);
        adv();
        eret = 0;
        @(negedge clk);
        expect_ctl("irq_after_eret", 0, '0, 1, 1, 0);
        check("irq_after_eret.in_handler", 64'(o_in_handler), 64'd0);
        adv();
        irq = 0;
        repeat (DC) adv();
        @(negedge clk);
        expect_ctl("vector2", 1, 28'h40, 0, 0, 1);
        adv();
        eret = 1; epc = 28'h5;
        @(negedge clk);
        expect_ctl("eret2", 1, 28'h5, 0, 0, 0);
        adv();
        clear_inputs();

        // 4. irq together with a taken branch: branch first, irq accepted next cycle.
        irq = 1; br_taken = 1; br_target = 28'h20;
        @(negedge clk);
        expect_ctl("irq_vs_br", 1, 28'h20, 0, 0, 0);
        adv();
        br_taken = 0;
        @(negedge clk);
        expect_ctl("irq_after_br", 0, '0, 1, 1, 0);
        adv();
        irq = 0;
        repeat (DC + 1) adv();
        eret = 1; epc = 28'h9;
        adv();
        clear_inputs();

        // irq with hazard stall is accepted; reset pulsed mid-DRAIN.
        irq = 1; hazard_stall = 1;
        @(negedge clk);
        expect_ctl("irq_vs_stall", 0, '0, 1, 1, 0);
        adv();
        clear_inputs();
        adv();
        arst = 1'b1;
        @(negedge clk);
        expect_ctl("reset_mid_drain", 0, '0, 0, 0, 0);
        adv();
        arst = 1'b0;
        for (int i = 0; i < DC + 2; i++) begin
            @(negedge clk);
            expect_ctl("post_reset", 0, '0, 0, 0, 0);
            check("post_reset.in_handler", 64'(o_in_handler), 64'd0);
            adv();
        end

        // eret outside a handler still redirects; plain hazard stalls.
        eret = 1; epc = 28'h9;
        @(negedge clk);
        expect_ctl("eret_no_handler", 1, 28'h9, 0, 0, 0);
        adv();
        clear_inputs();
        hazard_stall = 1;
        @(negedge clk);
        expect_ctl("hazard", 0, '0, 1, 0, 0);
        check("hazard.in_handler", 64'(o_in_handler), 64'd0);
        adv();
        clear_inputs();
        adv();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
